scene_loader: RTL
=================

# scene_loader

Sequencer that fills the ray tracer's bank of sphere registers from a synchronous scene ROM. On a start pulse it walks sphere indices 0..NUM_SPHERES-1, fetches each sphere's position (3 x 32-bit 16.16 fixed-point) and colour (3 x 8-bit), and writes it into the matching sphere register with a one-hot write strobe. It sits between the scene ROM and the per-sphere registers and replaces the hand-coded per-sphere load states in the top-level FSM.

## Interface
- NUM_SPHERES, 4, number of sphere registers in the bank (1..16)
- IDX_W, 4, width of sphere index / ROM address

- CLOCK_50  in  1  system clock; all logic on its rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle load request; honoured only in IDLE
- rom_addr  out  IDX_W  scene ROM address (sphere index)
- rom_pos  in  96  ROM position word {z,y,x}, each 32-bit 16.16, valid one cycle after rom_addr
- rom_col  in  24  ROM colour word {b,g,r}, valid one cycle after rom_addr
- sph_we  out  NUM_SPHERES  one-hot write strobe, one bit per sphere register
- sph_pos  out  96  position data to the sphere registers
- sph_col  out  24  colour data to the sphere registers
- busy  out  1  high while a load is in progress
- done  out  1  one-cycle pulse when the last sphere has been written
- scene_valid  out  1  high once a full load has completed; cleared at the start of the next load
- err_count  out  IDX_W+1  number of spheres rejected in the last load (see Configuration)

## Operation
- States: IDLE, ADDR, DATA, WRITE, FINISH.
- IDLE: busy=0, sph_we=0. When start=1: idx<=0, scene_valid<=0, err_count<=0, go to ADDR.
- ADDR: rom_addr=idx; go to DATA.
- DATA: latch rom_pos/rom_col into hold registers; go to WRITE.
- WRITE: sph_pos/sph_col = hold registers, sph_we = 1<<idx (zero if rejected). If idx==NUM_SPHERES-1 go to FINISH, else idx<=idx+1 and go to ADDR.
- FINISH: done=1, scene_valid<=1, go to IDLE.
- start during ADDR/DATA/WRITE/FINISH is ignored and not queued.
- start in the same cycle as Reset: Reset wins.
- rom_addr holds its last value outside ADDR. sph_pos/sph_col hold their last values outside WRITE.
- sph_we is never more than one bit high and is high only in WRITE.
- idx never exceeds NUM_SPHERES-1. There is no wrap within a load.

## Timing
- Reset values: state=IDLE, rom_addr=0, sph_we=0, sph_pos=0, sph_col=0, busy=0, done=0, scene_valid=0, err_count=0.
- Reset mid-load returns to IDLE on the next edge. Spheres already written keep their contents. scene_valid stays 0 and done does not pulse.
- Cycle 0 is the cycle start is sampled high in IDLE.
  - Sphere i: ADDR at cycle 1+3i, DATA at 2+3i, WRITE at 3+3i.
  - FINISH (done=1) at cycle 3*NUM_SPHERES+1.
  - scene_valid is first high at cycle 3*NUM_SPHERES+2.
  - IDLE is re-entered and start accepted again at cycle 3*NUM_SPHERES+2.
- busy is high in ADDR, DATA, WRITE and FINISH.
- The ROM has exactly one cycle of read latency. No ready/valid on the ROM side.

## Configuration
- SCENE_CHECK_EN defined:
  - In DATA, a sphere is rejected if its z coordinate is negative (rom_pos[95]=1, behind the camera) or its colour is all zero.
  - A rejected sphere gets no sph_we pulse in WRITE and err_count increments. The timing slot is still consumed.
  - scene_valid is set at FINISH only if err_count==0.
  - done pulses regardless.
- SCENE_CHECK_EN undefined:
  - No check; every sphere is written.
  - err_count is tied to 0.
  - scene_valid is set at every FINISH.

## Test plan
- Reset, NUM_SPHERES=4, ROM entry i = pos {0, i<<16, 0}, col 24'hFFFFFF; start pulse at cycle 0 -> sph_we = 0001, 0010, 0100, 1000 at cycles 3, 6, 9, 12 with matching data; done at cycle 13; scene_valid=1 from cycle 14.
- start re-pulsed at cycles 4 and 13 during a load -> ignored: exactly 4 write strobes, one done pulse; new start at cycle 14 accepted and scene_valid drops at cycle 15.
- Reset asserted at cycle 7 of a load -> cycle 8: state IDLE, all outputs at reset values; spheres 0 and 1 written, no done pulse.
- Reset and start high together in IDLE -> no load begins: busy stays 0, no sph_we.
- SCENE_CHECK_EN, entry 2 pos z = 32'hFFFF0000 -> no sph_we[2] at cycle 9, err_count=1, done at 13, scene_valid stays 0.
- SCENE_CHECK_EN undefined, same ROM as above -> sph_we[2] pulses at cycle 9, err_count=0, scene_valid=1 at 14.

Source files
------------

// File: rtl/scene_loader.sv
// Scene loader: copies NUM_SPHERES ROM entries into the sphere register bank, one-hot write per sphere.
// Latency: 3 cycles per sphere plus a FINISH cycle; the ROM read latency is a fixed single cycle.
// No backpressure; start is ignored while busy. `define SCENE_CHECK_EN rejects bad spheres.
module scene_loader #(
   parameter int NUM_SPHERES = 4,
   parameter int IDX_W       = 4
) (
   input  logic                   CLOCK_50,
   input  logic                   Reset,
   input  logic                   start,
   output logic [IDX_W-1:0]       rom_addr,
   input  logic [95:0]            rom_pos,
   input  logic [23:0]            rom_col,
   output logic [NUM_SPHERES-1:0] sph_we,
   output logic [95:0]            sph_pos,
   output logic [23:0]            sph_col,
   output logic                   busy,
   output logic                   done,
   output logic                   scene_valid,
   output logic [IDX_W:0]         err_count
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, FINISH} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] rom_addr_q, rom_addr_d;
   logic [95:0]      pos_q, pos_d;
   logic [23:0]      col_q, col_d;
   logic             valid_q, valid_d;
   logic             last_idx;
`ifdef SCENE_CHECK_EN
   logic             reject_q, reject_d;
   logic [IDX_W:0]   err_q, err_d;
`endif

   assign last_idx = (idx_q == IDX_W'(NUM_SPHERES - 1));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rom_addr_d = rom_addr_q;
      pos_d      = pos_q;
      col_d      = col_q;
      valid_d    = valid_q;
`ifdef SCENE_CHECK_EN
      reject_d   = reject_q;
      err_d      = err_q;
`endif
      sph_we     = '0;
      busy       = (state_q != IDLE);
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d      = '0;
               rom_addr_d = '0;
               valid_d    = 1'b0;
`ifdef SCENE_CHECK_EN
               err_d      = '0;
`endif
               state_d    = ADDR;
            end
         end
         ADDR: state_d = DATA;
         DATA: begin
            // Hold registers double as the sphere data outputs, so they change only on entry to WRITE.
            pos_d = rom_pos;
            col_d = rom_col;
`ifdef SCENE_CHECK_EN
            reject_d = rom_pos[95] | (rom_col == 24'd0);
            if (reject_d) err_d = err_q + 1'b1;
`endif
            state_d = WRITE;
         end
         WRITE: begin
            for (int i = 0; i < NUM_SPHERES; i++) begin
`ifdef SCENE_CHECK_EN
               sph_we[i] = (idx_q == IDX_W'(i)) & ~reject_q;
`else
               sph_we[i] = (idx_q == IDX_W'(i));
`endif
            end
            if (last_idx) begin
               state_d = FINISH;
            end else begin
               idx_d      = idx_q + 1'b1;
               rom_addr_d = idx_q + 1'b1;
               state_d    = ADDR;
            end
         end
         FINISH: begin
            done = 1'b1;
`ifdef SCENE_CHECK_EN
            valid_d = (err_q == '0);
`else
            valid_d = 1'b1;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         rom_addr_q <= '0;
         pos_q      <= '0;
         col_q      <= '0;
         valid_q    <= 1'b0;
`ifdef SCENE_CHECK_EN
         reject_q   <= 1'b0;
         err_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rom_addr_q <= rom_addr_d;
         pos_q      <= pos_d;
         col_q      <= col_d;
         valid_q    <= valid_d;
`ifdef SCENE_CHECK_EN
         reject_q   <= reject_d;
         err_q      <= err_d;
`endif
      end
   end

   assign rom_addr    = rom_addr_q;
   assign sph_pos     = pos_q;
   assign sph_col     = col_q;
   assign scene_valid = valid_q;
`ifdef SCENE_CHECK_EN
   assign err_count   = err_q;
`else
   assign err_count   = '0;
`endif

endmodule
